// File: rtl/edge_generator_if.sv
// ---------------------------------------------------------------------------
// edge_generator_if
//
// Purpose:
//   Groups the request and status signals of edge_generator into one bundle.
//   Clock and reset are not part of the bundle. They stay plain ports on the
//   block.
//
// Signals:
//   clk_en   tick qualifier. Counters only advance on cycles where it is 1.
//   trigger  request strobe, sampled on every clock.
//   len      pulse length in clk_en ticks. Captured when a request is
//            accepted or queued.
//   out      generated level.
//   busy     generator is not idle, or a request is waiting.
//   done     one-clock pulse in the cycle out goes back inactive.
//   toggle   flips once for every pulse that starts.
//   dropped  one-clock pulse when a trigger is thrown away.
//
// Modports:
//   master   the requester side (drives trigger/len/clk_en).
//   slave    the generator side (drives out/busy/done/toggle/dropped).
// ---------------------------------------------------------------------------
interface edge_generator_if #(
    parameter int unsigned WIDTH = 8
) ();

    logic             clk_en;
    logic             trigger;
    logic [WIDTH-1:0] len;
    logic             out;
    logic             busy;
    logic             done;
    logic             toggle;
    logic             dropped;

    modport master (
        output clk_en,
        output trigger,
        output len,
        input  out,
        input  busy,
        input  done,
        input  toggle,
        input  dropped
    );

    modport slave (
        input  clk_en,
        input  trigger,
        input  len,
        output out,
        output busy,
        output done,
        output toggle,
        output dropped
    );

endinterface

// File: rtl/edge_generator.sv
// ---------------------------------------------------------------------------
// edge_generator
//
// Purpose:
//   Produces a single registered pulse on out. The pulse lasts a
//   programmable number of clk_en ticks. A minimum inactive gap can be
//   enforced between pulses. While a pulse is running, a new trigger either
//   restarts the length count (RETRIGGER=1) or is held as one pending
//   request. Any further trigger while a request is already pending is
//   dropped.
//
// Parameters:
//   WIDTH      width of len and of the tick counter
//   OUT_LEVEL  active level of out (1 = active-high, 0 = active-low)
//   RETRIGGER  1 = trigger during ACTIVE reloads the count
//              0 = trigger during ACTIVE is queued
//   GAP_TICKS  minimum inactive clk_en ticks between pulses (0..255)
//
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      edge_generator_if.slave
//            (clk_en, trigger, len in; out, busy, done, toggle, dropped out)
// ---------------------------------------------------------------------------
module edge_generator #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          OUT_LEVEL = 1'b1,
    parameter bit          RETRIGGER = 1'b0,
    parameter int unsigned GAP_TICKS = 0
) (
    input  logic            clk,
    input  logic            reset_n,
    edge_generator_if.slave bus
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_GAP    = 2'd2;

    localparam logic [WIDTH-1:0] LEN_ONE  = WIDTH'(1);
    localparam logic [7:0]       GAP_LOAD = 8'(GAP_TICKS);

    logic [1:0]       state_q,   state_d;
    logic [WIDTH-1:0] count_q,   count_d;
    logic [7:0]       gap_q,     gap_d;
    logic             pending_q, pending_d;
    logic [WIDTH-1:0] pendLen_q, pendLen_d;
    logic             out_q,     out_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;
    logic             toggle_q,  toggle_d;
    logic             dropped_q, dropped_d;

    logic [WIDTH-1:0] effLen;
    logic             queueReq;
    logic             startPend;
    logic             dropEvent;

    // A length of zero would give no pulse at all, so it is stretched to one tick.
    assign effLen = (bus.len == '0) ? LEN_ONE : bus.len;

    // Next-state logic.
    // queueReq marks a trigger that must be held for later.
    // startPend marks that the held request is launched this cycle.
    // Both are resolved after the case statement. A trigger that arrives in
    // the same cycle the held request launches becomes the new held request.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        gap_d     = gap_q;
        pending_d = pending_q;
        pendLen_d = pendLen_q;
        toggle_d  = toggle_q;
        done_d    = 1'b0;
        queueReq  = 1'b0;
        startPend = 1'b0;
        dropEvent = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pending_q) begin
                    startPend = 1'b1;
                    state_d   = ST_ACTIVE;
                    count_d   = pendLen_q;
                    toggle_d  = ~toggle_q;
                    queueReq  = bus.trigger;
                end else if (bus.trigger) begin
                    state_d  = ST_ACTIVE;
                    count_d  = effLen;
                    toggle_d = ~toggle_q;
                end
            end

            ST_ACTIVE: begin
                // A reload takes priority over the terminal tick, so a
                // retriggered pulse never shows a done.
                if (RETRIGGER && bus.trigger) begin
                    count_d = effLen;
                end else begin
                    queueReq = bus.trigger;
                    if (bus.clk_en) begin
                        if (count_q == LEN_ONE) begin
                            done_d  = 1'b1;
                            count_d = '0;
                            if (GAP_TICKS > 0) begin
                                state_d = ST_GAP;
                                gap_d   = GAP_LOAD;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end else begin
                            count_d = count_q - LEN_ONE;
                        end
                    end
                end
            end

            ST_GAP: begin
                queueReq = bus.trigger;
                if (bus.clk_en) begin
                    if (gap_q == 8'd1) begin
                        gap_d = 8'd0;
                        // A held request launches here instead of passing
                        // through IDLE, so the gap is not stretched by a cycle.
                        if (pending_q) begin
                            startPend = 1'b1;
                            state_d   = ST_ACTIVE;
                            count_d   = pendLen_q;
                            toggle_d  = ~toggle_q;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        gap_d = gap_q - 8'd1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                count_d = '0;
                gap_d   = 8'd0;
            end
        endcase

        if (startPend) begin
            pending_d = 1'b0;
        end

        if (queueReq) begin
            if (!pending_q || startPend) begin
                pending_d = 1'b1;
                pendLen_d = effLen;
            end else begin
                dropEvent = 1'b1;
            end
        end
    end

    // Outputs are computed from the next state, so they line up with it in
    // the registered domain.
    // dropped is blocked for one cycle after it fires. This way back-to-back
    // discarded triggers never stretch it beyond one clock.
    always_comb begin
        out_d     = (state_d == ST_ACTIVE) ? OUT_LEVEL : ~OUT_LEVEL;
        busy_d    = (state_d != ST_IDLE) || pending_d;
        dropped_d = dropEvent && !dropped_q;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            gap_q     <= 8'd0;
            pending_q <= 1'b0;
            pendLen_q <= '0;
            out_q     <= ~OUT_LEVEL;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            toggle_q  <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            gap_q     <= gap_d;
            pending_q <= pending_d;
            pendLen_q <= pendLen_d;
            out_q     <= out_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            toggle_q  <= toggle_d;
            dropped_q <= dropped_d;
        end
    end

    assign bus.out     = out_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.toggle  = toggle_q;
    assign bus.dropped = dropped_q;

endmodule

// File: tb/tb_edge_generator.sv
// ---------------------------------------------------------------------------
// tb_edge_generator
//
// Directed bench for edge_generator. Four instances cover the parameter
// corners:
//   A  default                      (OUT_LEVEL=1, RETRIGGER=0, GAP_TICKS=0)
//   B  queued with gap              (RETRIGGER=0, GAP_TICKS=2)
//   C  retriggerable                (RETRIGGER=1, GAP_TICKS=0)
//   D  active-low output            (OUT_LEVEL=0)
// Cycle k means the window just after the k-th rising edge that follows a
// trigger. Inputs are driven and outputs sampled 1 time unit after the edge.
// ---------------------------------------------------------------------------
module tb_edge_generator;

    logic clk;
    logic reset_n;

    int checkCount;
    int passCount;
    int failCount;
    int outHigh;
    int donePulses;

    edge_generator_if #(.WIDTH(8)) busA ();
    edge_generator_if #(.WIDTH(8)) busB ();
    edge_generator_if #(.WIDTH(8)) busC ();
    edge_generator_if #(.WIDTH(8)) busD ();

    edge_generator #(.WIDTH(8), .OUT_LEVEL(1'b1), .RETRIGGER(1'b0), .GAP_TICKS(0))
        dutA (.clk(clk), .reset_n(reset_n), .bus(busA.slave));
    edge_generator #(.WIDTH(8), .OUT_LEVEL(1'b1), .RETRIGGER(1'b0), .GAP_TICKS(2))
        dutB (.clk(clk), .reset_n(reset_n), .bus(busB.slave));
    edge_generator #(.WIDTH(8), .OUT_LEVEL(1'b1), .RETRIGGER(1'b1), .GAP_TICKS(0))
        dutC (.clk(clk), .reset_n(reset_n), .bus(busC.slave));
    edge_generator #(.WIDTH(8), .OUT_LEVEL(1'b0), .RETRIGGER(1'b0), .GAP_TICKS(0))
        dutD (.clk(clk), .reset_n(reset_n), .bus(busD.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Drive the instances selected by mask (bit0=A .. bit3=D).
    // Every instance that is not selected has its trigger held low.
    task automatic applyStimulus(input logic [3:0] mask, input logic trig,
                                 input logic [7:0] l, input logic en);
        busA.trigger = mask[0] ? trig : 1'b0;
        busB.trigger = mask[1] ? trig : 1'b0;
        busC.trigger = mask[2] ? trig : 1'b0;
        busD.trigger = mask[3] ? trig : 1'b0;
        if (mask[0]) begin busA.len = l; busA.clk_en = en; end
        if (mask[1]) begin busB.len = l; busB.clk_en = en; end
        if (mask[2]) begin busC.len = l; busC.clk_en = en; end
        if (mask[3]) begin busD.len = l; busD.clk_en = en; end
    endtask

    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    task automatic checkValue(input string tag, input int observed, input int expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        failCount  = 0;
        reset_n    = 1'b0;
        applyStimulus(4'b1111, 1'b0, 8'd0, 1'b1);

        // Reset values. A trigger is held during reset and must not be queued.
        busA.trigger = 1'b1;
        #12;
        checkOutput("rst A out",     busA.out,     1'b0);
        checkOutput("rst A busy",    busA.busy,    1'b0);
        checkOutput("rst A done",    busA.done,    1'b0);
        checkOutput("rst A toggle",  busA.toggle,  1'b0);
        checkOutput("rst A dropped", busA.dropped, 1'b0);
        checkOutput("rst D out",     busD.out,     1'b1);
        busA.trigger = 1'b0;
        stepCycle();
        reset_n = 1'b1;
        stepCycle();
        checkOutput("post-rst A busy", busA.busy, 1'b0);
        checkOutput("post-rst A out",  busA.out,  1'b0);

        // Basic pulse, len=5, on A and on the active-low D.
        $display("[TB] len=5 basic pulse, active-high and active-low");
        applyStimulus(4'b1001, 1'b1, 8'd5, 1'b1);
        stepCycle();
        applyStimulus(4'b1001, 1'b0, 8'd5, 1'b1);
        for (int k = 1; k <= 7; k++) begin
            checkOutput($sformatf("A033 out c%0d", k),  busA.out,  (k <= 5));
            checkOutput($sformatf("D038 out c%0d", k),  busD.out,  !(k <= 5));
            checkOutput($sformatf("A033 done c%0d", k), busA.done, (k == 6));
            checkOutput($sformatf("A033 busy c%0d", k), busA.busy, (k <= 5));
            if (k < 7) stepCycle();
        end
        checkOutput("A033 toggle", busA.toggle, 1'b1);
        checkOutput("D038 toggle", busD.toggle, 1'b1);

        // clk_en every 4th clock with len=3 stretches the pulse to 12 clocks.
        $display("[TB] sparse clk_en");
        outHigh    = 0;
        donePulses = 0;
        for (int k = 0; k < 16; k++) begin
            applyStimulus(4'b0001, (k == 0), 8'd3, ((k % 4) == 0));
            stepCycle();
            if (busA.out)  outHigh++;
            if (busA.done) donePulses++;
        end
        applyStimulus(4'b0001, 1'b0, 8'd3, 1'b1);
        checkValue("A034 high clocks", outHigh, 12);
        checkValue("A034 done pulses", donePulses, 1);
        checkOutput("A034 toggle", busA.toggle, 1'b0);

        // RETRIGGER=0: trigger on the terminal tick gives done, then a queued restart.
        $display("[TB] queued trigger on terminal tick");
        applyStimulus(4'b0001, 1'b1, 8'd2, 1'b1);
        stepCycle();
        applyStimulus(4'b0001, 1'b0, 8'd2, 1'b1);
        stepCycle();
        applyStimulus(4'b0001, 1'b1, 8'd2, 1'b1);
        stepCycle();
        applyStimulus(4'b0001, 1'b0, 8'd2, 1'b1);
        checkOutput("A027 c3 done", busA.done, 1'b1);
        checkOutput("A027 c3 out",  busA.out,  1'b0);
        checkOutput("A027 c3 busy", busA.busy, 1'b1);
        stepCycle();
        checkOutput("A027 c4 out",    busA.out,    1'b1);
        checkOutput("A027 c4 toggle", busA.toggle, 1'b0);
        checkOutput("A027 c4 done",   busA.done,   1'b0);
        stepCycle();
        stepCycle();
        checkOutput("A027 c6 done", busA.done, 1'b1);
        checkOutput("A027 c6 busy", busA.busy, 1'b0);

        // Gap of 2 ticks. Triggers at 0,2,3: the second is queued, the third dropped.
        $display("[TB] gap with queued and dropped triggers");
        for (int k = 0; k <= 12; k++) begin
            applyStimulus(4'b0010, (k == 0 || k == 2 || k == 3), 8'd4, 1'b1);
            stepCycle();
            checkOutput($sformatf("B035 out c%0d", k + 1), busB.out,
                        ((k + 1) >= 1 && (k + 1) <= 4) || ((k + 1) >= 7 && (k + 1) <= 10));
            checkOutput($sformatf("B035 dropped c%0d", k + 1), busB.dropped, ((k + 1) == 4));
            checkOutput($sformatf("B035 done c%0d", k + 1), busB.done,
                        ((k + 1) == 5 || (k + 1) == 11));
            checkOutput($sformatf("B035 busy c%0d", k + 1), busB.busy, ((k + 1) <= 12));
        end
        applyStimulus(4'b0010, 1'b0, 8'd4, 1'b1);
        checkOutput("B035 toggle", busB.toggle, 1'b0);

        // Back-to-back discarded triggers keep dropped to a single clock.
        $display("[TB] consecutive drops");
        stepCycle();
        for (int k = 0; k <= 4; k++) begin
            applyStimulus(4'b0010, (k <= 3), 8'd4, 1'b1);
            stepCycle();
            checkOutput($sformatf("B029 dropped c%0d", k + 1), busB.dropped, ((k + 1) == 3));
        end
        applyStimulus(4'b0010, 1'b0, 8'd4, 1'b1);
        repeat (9) stepCycle();
        checkOutput("B029 idle busy", busB.busy, 1'b0);

        // RETRIGGER=1: triggers at 0 and 3 merge into one pulse covering cycles 1..7.
        $display("[TB] retrigger extends pulse");
        for (int k = 0; k <= 8; k++) begin
            applyStimulus(4'b0100, (k == 0 || k == 3), 8'd4, 1'b1);
            stepCycle();
            checkOutput($sformatf("C036 out c%0d", k + 1),  busC.out,  ((k + 1) <= 7));
            checkOutput($sformatf("C036 done c%0d", k + 1), busC.done, ((k + 1) == 8));
        end
        checkOutput("C036 toggle", busC.toggle, 1'b1);

        // RETRIGGER=1: reload beats the terminal tick, so no done appears at c3.
        $display("[TB] retrigger on terminal tick");
        for (int k = 0; k <= 5; k++) begin
            applyStimulus(4'b0100, (k == 0 || k == 2), 8'd2, 1'b1);
            stepCycle();
            checkOutput($sformatf("C027 out c%0d", k + 1),  busC.out,  ((k + 1) <= 4));
            checkOutput($sformatf("C027 done c%0d", k + 1), busC.done, ((k + 1) == 5));
        end
        applyStimulus(4'b0100, 1'b0, 8'd2, 1'b1);
        checkOutput("C027 toggle", busC.toggle, 1'b0);

        // len=0 behaves as len=1.
        $display("[TB] zero length and mid-pulse reset");
        applyStimulus(4'b0001, 1'b1, 8'd0, 1'b1);
        stepCycle();
        applyStimulus(4'b0001, 1'b0, 8'd0, 1'b1);
        checkOutput("A037 len0 c1 out", busA.out, 1'b1);
        stepCycle();
        checkOutput("A037 len0 c2 out",  busA.out,    1'b0);
        checkOutput("A037 len0 c2 done", busA.done,   1'b1);
        checkOutput("A037 len0 toggle",  busA.toggle, 1'b1);

        // Reset in the middle of a len=10 pulse aborts it without a done.
        applyStimulus(4'b0001, 1'b1, 8'd10, 1'b1);
        stepCycle();
        applyStimulus(4'b0001, 1'b0, 8'd10, 1'b1);
        stepCycle();
        checkOutput("A037 c2 out", busA.out, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("A037 rst out",    busA.out,    1'b0);
        checkOutput("A037 rst toggle", busA.toggle, 1'b0);
        checkOutput("A037 rst busy",   busA.busy,   1'b0);
        checkOutput("A037 rst done",   busA.done,   1'b0);
        stepCycle();
        checkOutput("A037 held done", busA.done, 1'b0);
        reset_n = 1'b1;
        stepCycle();
        checkOutput("A037 rel done", busA.done, 1'b0);
        checkOutput("A037 rel out",  busA.out,  1'b0);
        applyStimulus(4'b0001, 1'b1, 8'd2, 1'b1);
        stepCycle();
        applyStimulus(4'b0001, 1'b0, 8'd2, 1'b1);
        checkOutput("A031 restart out",    busA.out,    1'b1);
        checkOutput("A031 restart toggle", busA.toggle, 1'b1);
        checkOutput("A031 restart busy",   busA.busy,   1'b1);
        repeat (3) stepCycle();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
